// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: state machine that sequences a multi-cycle RV32I
// datapath through one shared ALU and one shared memory port.
//
// state    | meaning
// FETCH    | read instruction at PC, PC <= PC + 4 when memory is ready
// DECODE   | ALUOut <= OldPC + imm (branch/JAL/AUIPC target), dispatch on opcode
// MEMADR   | ALUOut <= rs1 + imm (load/store address)
// MEMREAD  | read data memory at ALUOut
// MEMWB    | rd <= loaded data
// MEMWRITE | write data memory at ALUOut
// EXECR    | ALUOut <= rs1 op rs2
// EXECI    | ALUOut <= rs1 op imm
// ALUWB    | rd <= ALUOut
// JAL      | PC <= target, ALUOut <= OldPC + 4
// BRANCH   | compare rs1/rs2, PC <= target when taken
// JALR     | PC <= rs1 + imm
// LINK     | ALUOut <= OldPC + 4
// LUI      | rd <= ImmExt
// TRAP     | illegal opcode seen, parked until reset
module multicycle_control_unit #(
  parameter bit MEM_WAIT = 1'b1,
  parameter bit EXT_OPS  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       lt,
  input  logic       ltu,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       memwrite,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       regwrite,
  output logic       adrsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] resultsrc,
  output logic [2:0] immsrc,
  output logic [3:0] alucontrol,
  output logic       illegal,
  output logic       retire,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BRANCH   = 4'd10,
    S_JALR     = 4'd11,
    S_LINK     = 4'd12,
    S_LUI      = 4'd13,
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  state_t cur_state, next_state;
  logic   ready, taken;
  logic   mem_req_raw, memwrite_raw, irwrite_raw, pcwrite_raw, regwrite_raw, retire_raw;

  // alt selects sub/sra; callers decide when funct7b5 is meaningful
  function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_decode = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_decode = ALU_SLL;
      3'b010:  alu_decode = ALU_SLT;
      3'b011:  alu_decode = ALU_SLTU;
      3'b100:  alu_decode = ALU_XOR;
      3'b101:  alu_decode = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_decode = ALU_OR;
      default: alu_decode = ALU_AND;
    endcase
  endfunction

  assign ready = MEM_WAIT ? mem_ready : 1'b1;

  // branch condition from the ALU flags of rs1 - rs2
  always_comb begin
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = ~zero;
      3'b100:  taken = lt;
      3'b101:  taken = ~lt;
      3'b110:  taken = ltu;
      3'b111:  taken = ~ltu;
      default: taken = 1'b0;
    endcase
  end

  // immediate format follows the opcode regardless of state
  always_comb begin
    case (op)
      OP_STORE:          immsrc = 3'b001;
      OP_BRANCH:         immsrc = 3'b010;
      OP_JAL:            immsrc = 3'b011;
      OP_LUI, OP_AUIPC:  immsrc = 3'b100;
      default:           immsrc = 3'b000;
    endcase
  end

  // state register; reset wins over every transition, including TRAP
  always_ff @(posedge clk) begin
    if (reset) cur_state <= S_FETCH;
    else       cur_state <= next_state;
  end

  // next-state and per-state datapath controls
  always_comb begin
    next_state   = cur_state;
    mem_req_raw  = 1'b0;
    memwrite_raw = 1'b0;
    irwrite_raw  = 1'b0;
    pcwrite_raw  = 1'b0;
    regwrite_raw = 1'b0;
    retire_raw   = 1'b0;
    adrsrc       = 1'b0;
    alusrca      = 2'b00;
    alusrcb      = 2'b00;
    resultsrc    = 2'b00;
    alucontrol   = ALU_ADD;
    illegal      = 1'b0;
    case (cur_state)
      S_FETCH: begin
        mem_req_raw = 1'b1;
        alusrcb     = 2'b10;
        resultsrc   = 2'b10;
        irwrite_raw = ready;
        pcwrite_raw = ready;
        if (ready) next_state = S_DECODE;
      end
      S_DECODE: begin
        alusrca = 2'b01;
        alusrcb = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: next_state = S_MEMADR;
          OP_R:              next_state = S_EXECR;
          OP_I:              next_state = S_EXECI;
          OP_JAL:            next_state = S_JAL;
          OP_BRANCH:         next_state = S_BRANCH;
          OP_JALR:           next_state = EXT_OPS ? S_JALR  : S_TRAP;
          OP_LUI:            next_state = EXT_OPS ? S_LUI   : S_TRAP;
          OP_AUIPC:          next_state = EXT_OPS ? S_ALUWB : S_TRAP;
          default:           next_state = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alusrca    = 2'b10;
        alusrcb    = 2'b01;
        next_state = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req_raw = 1'b1;
        adrsrc      = 1'b1;
        if (ready) next_state = S_MEMWB;
      end
      S_MEMWB: begin
        resultsrc    = 2'b01;
        regwrite_raw = 1'b1;
        retire_raw   = 1'b1;
        next_state   = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req_raw  = 1'b1;
        adrsrc       = 1'b1;
        memwrite_raw = 1'b1;
        if (ready) begin
          retire_raw = 1'b1;
          next_state = S_FETCH;
        end
      end
      S_EXECR: begin
        alusrca    = 2'b10;
        alucontrol = alu_decode(funct3, funct7b5);
        next_state = S_ALUWB;
      end
      S_EXECI: begin
        alusrca    = 2'b10;
        alusrcb    = 2'b01;
        // instr[30] is part of the immediate except for srai
        alucontrol = alu_decode(funct3, funct7b5 & (funct3 == 3'b101));
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite_raw = 1'b1;
        retire_raw   = 1'b1;
        next_state   = S_FETCH;
      end
      S_JAL: begin
        pcwrite_raw = 1'b1;
        alusrca     = 2'b01;
        alusrcb     = 2'b10;
        next_state  = S_ALUWB;
      end
      S_BRANCH: begin
        alusrca     = 2'b10;
        alucontrol  = ALU_SUB;
        retire_raw  = 1'b1;
        pcwrite_raw = taken;
        next_state  = S_FETCH;
      end
      S_JALR: begin
        alusrca     = 2'b10;
        alusrcb     = 2'b01;
        resultsrc   = 2'b10;
        pcwrite_raw = 1'b1;
        next_state  = S_LINK;
      end
      S_LINK: begin
        alusrca    = 2'b01;
        alusrcb    = 2'b10;
        next_state = S_ALUWB;
      end
      S_LUI: begin
        resultsrc    = 2'b11;
        regwrite_raw = 1'b1;
        retire_raw   = 1'b1;
        next_state   = S_FETCH;
      end
      S_TRAP: begin
        illegal = 1'b1;
      end
      default: begin
        next_state = S_TRAP;
      end
    endcase
  end

  // no write or memory strobe may escape while reset is held
  assign mem_req  = mem_req_raw  & ~reset;
  assign memwrite = memwrite_raw & ~reset;
  assign irwrite  = irwrite_raw  & ~reset;
  assign pcwrite  = pcwrite_raw  & ~reset;
  assign regwrite = regwrite_raw & ~reset;
  assign retire   = retire_raw   & ~reset;
  assign state    = cur_state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench: each stimulus cycle pushes its expected outputs, a
// negedge monitor pops and compares. A second instance (EXT_OPS=0,
// MEM_WAIT=0) has its own small queue.
module tb_multicycle_control_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic [6:0] op = '0;
  logic [2:0] funct3 = '0;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0, lt = 1'b0, ltu = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, memwrite, irwrite, pcwrite, regwrite, adrsrc, illegal, retire;
  logic [1:0] alusrca, alusrcb, resultsrc;
  logic [2:0] immsrc;
  logic [3:0] alucontrol, state;

  logic       reset2 = 1'b1;
  logic [6:0] op2 = '0;
  logic       mem_ready2 = 1'b0;
  logic       mem_req2, memwrite2, irwrite2, pcwrite2, regwrite2, adrsrc2, illegal2, retire2;
  logic [1:0] alusrca2, alusrcb2, resultsrc2;
  logic [2:0] immsrc2;
  logic [3:0] alucontrol2, state2;

  multicycle_control_unit #(.MEM_WAIT(1'b1), .EXT_OPS(1'b1)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
    .mem_req(mem_req), .memwrite(memwrite), .irwrite(irwrite), .pcwrite(pcwrite),
    .regwrite(regwrite), .adrsrc(adrsrc), .alusrca(alusrca), .alusrcb(alusrcb),
    .resultsrc(resultsrc), .immsrc(immsrc), .alucontrol(alucontrol),
    .illegal(illegal), .retire(retire), .state(state)
  );

  multicycle_control_unit #(.MEM_WAIT(1'b0), .EXT_OPS(1'b0)) dut_n (
    .clk(clk), .reset(reset2), .op(op2), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready2),
    .mem_req(mem_req2), .memwrite(memwrite2), .irwrite(irwrite2), .pcwrite(pcwrite2),
    .regwrite(regwrite2), .adrsrc(adrsrc2), .alusrca(alusrca2), .alusrcb(alusrcb2),
    .resultsrc(resultsrc2), .immsrc(immsrc2), .alucontrol(alucontrol2),
    .illegal(illegal2), .retire(retire2), .state(state2)
  );

  // strobe vector order: mem_req memwrite irwrite pcwrite regwrite retire illegal
  localparam logic [6:0] MR = 7'b1000000, MW = 7'b0100000, IW = 7'b0010000,
                         PW = 7'b0001000, RW = 7'b0000100, RT = 7'b0000010,
                         IL = 7'b0000001, NONE = 7'b0000000;
  // mux vector order: adrsrc alusrca alusrcb
  localparam logic [4:0] M_FETCH = 5'b0_00_10, M_DEC = 5'b0_01_01, M_RS1_IMM = 5'b0_10_01,
                         M_RS1_RS2 = 5'b0_10_00, M_MEM = 5'b1_00_00, M_OLD4 = 5'b0_01_10,
                         M_NONE = 5'b0_00_00;
  localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_AND = 4'd2, A_OR = 4'd3, A_XOR = 4'd4,
                         A_SLT = 4'd5, A_SLL = 4'd6, A_SRL = 4'd7, A_SRA = 4'd8, A_SLTU = 4'd9;

  typedef enum int {K_R, K_I, K_LD, K_ST, K_JAL, K_BR, K_JALR, K_LUI, K_AUIPC, K_BAD} kind_t;

  typedef struct packed {
    logic       rst;
    logic [3:0] st;
    logic [6:0] strb;
    logic [4:0] mux;
    logic [3:0] alu;
    logic [1:0] res;
    logic [2:0] imm;
  } exp_t;

  typedef struct packed {
    logic [3:0] st;
    logic       il;
    logic       rt;
  } exp2_t;

  exp_t  sb[$];
  exp2_t sb2[$];
  int    n_cmp = 0;
  int    n_err = 0;
  bit    done2 = 1'b0;

  logic [6:0] i_op;
  logic [2:0] i_f3, i_imm;
  logic       i_b5, i_zero, i_lt, i_ltu;
  logic [6:0] i_op2;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, got, want, $time);
    end
  endtask

  function automatic logic rb();
    return logic'($urandom_range(0, 1));
  endfunction

  function automatic logic [6:0] kind_op(input kind_t k);
    case (k)
      K_R:     return 7'b0110011;
      K_I:     return 7'b0010011;
      K_LD:    return 7'b0000011;
      K_ST:    return 7'b0100011;
      K_JAL:   return 7'b1101111;
      K_BR:    return 7'b1100011;
      K_JALR:  return 7'b1100111;
      K_LUI:   return 7'b0110111;
      K_AUIPC: return 7'b0010111;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [2:0] kind_imm(input kind_t k);
    case (k)
      K_ST:           return 3'b001;
      K_BR:           return 3'b010;
      K_JAL:          return 3'b011;
      K_LUI, K_AUIPC: return 3'b100;
      default:        return 3'b000;
    endcase
  endfunction

  function automatic bit is_legal(input logic [6:0] o);
    for (int k = 0; k < 9; k++)
      if (o == kind_op(kind_t'(k))) return 1'b1;
    return 1'b0;
  endfunction

  // RV32I mnemonic for funct3 with alt = "sub/sra" variant
  function automatic logic [3:0] ref_alu(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    return alt ? A_SUB : A_ADD;   // add/sub
      3'd1:    return A_SLL;
      3'd2:    return A_SLT;
      3'd3:    return A_SLTU;
      3'd4:    return A_XOR;
      3'd5:    return alt ? A_SRA : A_SRL;
      3'd6:    return A_OR;
      default: return A_AND;
    endcase
  endfunction

  function automatic bit ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return $signed(a) <  $signed(b);
      3'd5:    return $signed(a) >= $signed(b);
      3'd6:    return a <  b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // one clock cycle of the main DUT with its expected outputs
  task automatic add(input logic [3:0] st, input logic [6:0] strb, input logic [4:0] mux,
                     input logic [3:0] alu, input logic [1:0] res, input logic rdy);
    exp_t e;
    @(posedge clk); #1;
    reset = 1'b0; op = i_op; funct3 = i_f3; funct7b5 = i_b5;
    zero = i_zero; lt = i_lt; ltu = i_ltu; mem_ready = rdy;
    e.rst = 1'b0; e.st = st; e.strb = strb; e.mux = mux; e.alu = alu; e.res = res; e.imm = i_imm;
    sb.push_back(e);
  endtask

  task automatic rst_cycle(input logic rdy);
    exp_t e;
    @(posedge clk); #1;
    reset = 1'b1; mem_ready = rdy;
    e = '0;
    e.rst = 1'b1;
    sb.push_back(e);
  endtask

  task automatic fetch_decode(input int wf);
    for (int i = 0; i < wf; i++) add(4'd0, MR, M_FETCH, A_ADD, 2'b10, 1'b0);
    add(4'd0, MR | IW | PW, M_FETCH, A_ADD, 2'b10, 1'b1);
    add(4'd1, NONE, M_DEC, A_ADD, 2'b00, rb());
  endtask

  task automatic aluwb();
    add(4'd8, RW | RT, M_NONE, A_ADD, 2'b00, rb());
  endtask

  task automatic run_instr(input kind_t k, input logic [2:0] f3, input logic b5, input int wf,
                           input int wm, input logic [31:0] a, input logic [31:0] b,
                           input logic [6:0] bad_op, input int ntrap);
    i_op = (k == K_BAD) ? bad_op : kind_op(k);
    i_imm = kind_imm(k);
    i_f3 = f3; i_b5 = b5;
    i_zero = ((a - b) == 32'd0); i_lt = ($signed(a) < $signed(b)); i_ltu = (a < b);
    fetch_decode(wf);
    case (k)
      K_R: begin
        add(4'd6, NONE, M_RS1_RS2, ref_alu(f3, b5), 2'b00, rb());
        aluwb();
      end
      K_I: begin
        add(4'd7, NONE, M_RS1_IMM, ref_alu(f3, b5 && f3 == 3'd5), 2'b00, rb());
        aluwb();
      end
      K_LD: begin
        add(4'd2, NONE, M_RS1_IMM, A_ADD, 2'b00, rb());
        for (int i = 0; i < wm; i++) add(4'd3, MR, M_MEM, A_ADD, 2'b00, 1'b0);
        add(4'd3, MR, M_MEM, A_ADD, 2'b00, 1'b1);
        add(4'd4, RW | RT, M_NONE, A_ADD, 2'b01, rb());
      end
      K_ST: begin
        add(4'd2, NONE, M_RS1_IMM, A_ADD, 2'b00, rb());
        for (int i = 0; i < wm; i++) add(4'd5, MR | MW, M_MEM, A_ADD, 2'b00, 1'b0);
        add(4'd5, MR | MW | RT, M_MEM, A_ADD, 2'b00, 1'b1);
      end
      K_JAL: begin
        add(4'd9, PW, M_OLD4, A_ADD, 2'b00, rb());
        aluwb();
      end
      K_BR: begin
        add(4'd10, RT | (ref_taken(f3, a, b) ? PW : NONE), M_RS1_RS2, A_SUB, 2'b00, rb());
      end
      K_JALR: begin
        add(4'd11, PW, M_RS1_IMM, A_ADD, 2'b10, rb());
        add(4'd12, NONE, M_OLD4, A_ADD, 2'b00, rb());
        aluwb();
      end
      K_LUI:   add(4'd13, RW | RT, M_NONE, A_ADD, 2'b11, rb());
      K_AUIPC: aluwb();
      default: begin
        for (int i = 0; i < ntrap; i++) add(4'd15, IL, M_NONE, A_ADD, 2'b00, rb());
        rst_cycle(rb());
      end
    endcase
  endtask

  // main-instance monitor
  exp_t ce;
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      ce = sb.pop_front();
      chk("strobes", 32'({mem_req, memwrite, irwrite, pcwrite, regwrite, retire, illegal & ~ce.rst}),
          32'(ce.strb));
      if (!ce.rst) begin
        chk("state", 32'(state), 32'(ce.st));
        chk("mux", 32'({adrsrc, alusrca, alusrcb}), 32'(ce.mux));
        chk("alucontrol", 32'(alucontrol), 32'(ce.alu));
        chk("resultsrc", 32'(resultsrc), 32'(ce.res));
        chk("immsrc", 32'(immsrc), 32'(ce.imm));
      end
    end
  end

  // EXT_OPS=0 / MEM_WAIT=0 instance monitor
  exp2_t ce2;
  always @(negedge clk) begin
    if (sb2.size() > 0) begin
      ce2 = sb2.pop_front();
      chk("n_state", 32'(state2), 32'(ce2.st));
      chk("n_illegal", 32'(illegal2), 32'(ce2.il));
      chk("n_retire", 32'(retire2), 32'(ce2.rt));
    end
  end

  task automatic add2(input logic [3:0] st, input logic il, input logic rt);
    exp2_t e;
    @(posedge clk); #1;
    reset2 = 1'b0; op2 = i_op2; mem_ready2 = 1'b0;
    e.st = st; e.il = il; e.rt = rt;
    sb2.push_back(e);
  endtask

  task automatic rst2();
    @(posedge clk); #1;
    reset2 = 1'b1;
  endtask

  initial begin
    kind_t ext_k[3];
    ext_k[0] = K_JALR; ext_k[1] = K_LUI; ext_k[2] = K_AUIPC;
    rst2();
    for (int j = 0; j < 3; j++) begin
      i_op2 = kind_op(ext_k[j]);
      add2(4'd0, 1'b0, 1'b0);
      add2(4'd1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) add2(4'd15, 1'b1, 1'b0);
      rst2();
    end
    i_op2 = kind_op(K_R);
    add2(4'd0, 1'b0, 1'b0);
    add2(4'd1, 1'b0, 1'b0);
    add2(4'd6, 1'b0, 1'b0);
    add2(4'd8, 1'b0, 1'b1);
    add2(4'd0, 1'b0, 1'b0);
    done2 = 1'b1;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, sb=%0d", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b;
    logic [6:0]  bop;
    kind_t       k;
    i_op = '0; i_f3 = '0; i_b5 = 1'b0; i_imm = '0; i_zero = 1'b0; i_lt = 1'b0; i_ltu = 1'b0;
    rst_cycle(1'b0);
    rst_cycle(1'b1);

    // directed cases
    run_instr(K_R,   3'b000, 1'b1, 0, 0, 32'd9, 32'd4, 7'd0, 0);    // sub
    run_instr(K_I,   3'b000, 1'b1, 0, 0, 32'd1, 32'd1, 7'd0, 0);    // addi, instr[30]=1
    run_instr(K_I,   3'b101, 1'b1, 0, 0, 32'd1, 32'd1, 7'd0, 0);    // srai
    run_instr(K_LD,  3'b010, 1'b0, 2, 3, 32'd0, 32'd0, 7'd0, 0);    // lw, 10 cycles
    run_instr(K_BR,  3'b000, 1'b0, 0, 0, 32'd1, 32'd2, 7'd0, 0);    // beq not taken
    run_instr(K_BR,  3'b111, 1'b0, 0, 0, 32'd5, 32'd3, 7'd0, 0);    // bgeu taken
    run_instr(K_JALR, 3'b000, 1'b0, 0, 0, 32'd0, 32'd0, 7'd0, 0);
    run_instr(K_LUI, 3'b000, 1'b0, 0, 0, 32'd0, 32'd0, 7'd0, 0);
    run_instr(K_AUIPC, 3'b000, 1'b0, 1, 0, 32'd0, 32'd0, 7'd0, 0);
    run_instr(K_ST,  3'b010, 1'b0, 0, 2, 32'd0, 32'd0, 7'd0, 0);
    run_instr(K_BAD, 3'b000, 1'b0, 0, 0, 32'd0, 32'd0, 7'b1111111, 20);

    // reset in the middle of a store wait: abort, no write strobe
    i_op = kind_op(K_ST); i_imm = kind_imm(K_ST); i_f3 = 3'b010; i_b5 = 1'b0;
    fetch_decode(0);
    add(4'd2, NONE, M_RS1_IMM, A_ADD, 2'b00, 1'b0);
    add(4'd5, MR | MW, M_MEM, A_ADD, 2'b00, 1'b0);
    add(4'd5, MR | MW, M_MEM, A_ADD, 2'b00, 1'b0);
    rst_cycle(1'b1);

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      k = kind_t'($urandom_range(0, 9));
      a = $urandom();
      b = ($urandom_range(0, 3) == 0) ? a : $urandom();
      if ($urandom_range(0, 3) == 0) b = {~a[31], a[30:0]};
      do bop = 7'($urandom_range(0, 127)); while (is_legal(bop));
      run_instr(k, 3'($urandom_range(0, 7)), rb(), $urandom_range(0, 3), $urandom_range(0, 3),
                a, b, bop, $urandom_range(1, 4));
    end

    repeat (3) @(posedge clk);
    chk("sb_drain", 32'(sb.size()), 32'd0);
    chk("ext_off_done", 32'(done2), 32'd1);
    chk("sb2_drain", 32'(sb2.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
